// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit framing engine (optional break via UART_TX_BREAK_EN)
//
// Builds a start / 7-or-8 data / optional parity / stop frame into a shift
// register on load, shifts one bit out per btu from the bit time counter,
// and holds doit high for exactly FRAME_BITS bit times.
// Define UART_TX_BREAK_EN to add i_brk, which forces the line low.

module uart_tx_engine #(
  parameter int FRAME_BITS = 11
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic       i_brk,
`endif
  input  logic       i_load,
  input  logic [7:0] i_out_port,
  input  logic       i_eight,
  input  logic       i_pen,
  input  logic       i_ohel,
  input  logic       i_btu,
  output logic       o_doit,
  output logic       o_tx,
  output logic       o_txrdy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t                r_state;
  logic                  r_doit;
  logic                  r_txrdy;
  logic [3:0]            r_count;
  logic [FRAME_BITS-1:0] r_sr;

  logic                  w_par7;
  logic                  w_par8;
  logic                  w_bit8;
  logic                  w_bit9;
  logic                  w_load_ok;
  logic                  w_line;
  logic [FRAME_BITS-1:0] w_load_sr;

  // Parity over the data bits actually sent; ohel=1 flips even to odd.
  assign w_par7 = (^i_out_port[6:0]) ^ i_ohel;
  assign w_par8 = (^i_out_port[7:0]) ^ i_ohel;

  // Bits 8 and 9 of the frame depend on data width and parity enable.
  always_comb begin
    w_bit8 = 1'b1;
    w_bit9 = 1'b1;
    case ({i_eight, i_pen})
      2'b00:   begin w_bit8 = 1'b1;          w_bit9 = 1'b1;   end
      2'b01:   begin w_bit8 = w_par7;        w_bit9 = 1'b1;   end
      2'b10:   begin w_bit8 = i_out_port[7]; w_bit9 = 1'b1;   end
      default: begin w_bit8 = i_out_port[7]; w_bit9 = w_par8; end
    endcase
  end

  // Frame image: stop bits on top, start bit in bit 0 so it goes out first.
  assign w_load_sr = {{(FRAME_BITS-10){1'b1}}, w_bit9, w_bit8, i_out_port[6:0], 1'b0};

  // Break holds off new frames; without it, load is taken as-is.
`ifdef UART_TX_BREAK_EN
  assign w_load_ok = i_load & ~i_brk;
`else
  assign w_load_ok = i_load;
`endif

  // Frame sequencer: load, shift on btu, retire after the last stop bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_doit  <= 1'b0;
      r_txrdy <= 1'b1;
      r_count <= 4'd0;
      r_sr    <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_load_ok) begin
            r_state <= S_BUSY;
            r_doit  <= 1'b1;
            r_txrdy <= 1'b0;
            r_count <= 4'd0;
            r_sr    <= w_load_sr;
          end
        end
        S_BUSY: begin
          if (i_btu) begin
            if (r_count == LAST_BIT) begin
              r_state <= S_IDLE;
              r_doit  <= 1'b0;
              r_txrdy <= 1'b1;
              r_count <= 4'd0;
              r_sr    <= '1;
            end else begin
              r_count <= r_count + 4'd1;
              r_sr    <= {1'b1, r_sr[FRAME_BITS-1:1]};
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_doit  <= 1'b0;
          r_txrdy <= 1'b1;
          r_count <= 4'd0;
          r_sr    <= '1;
        end
      endcase
    end
  end

  // Line is idle-high outside a frame; reset reaches it through r_doit/r_sr.
  assign w_line = r_doit ? r_sr[0] : 1'b1;

`ifdef UART_TX_BREAK_EN
  assign o_tx = i_brk ? 1'b0 : w_line;
`else
  assign o_tx = w_line;
`endif

  assign o_doit  = r_doit;
  assign o_txrdy = r_txrdy;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - self-checking bench for uart_tx_engine

module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] out_port;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       btu;
  logic       doit;
  logic       tx;
  logic       txrdy;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.FRAME_BITS(11)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
`ifdef UART_TX_BREAK_EN
    .i_brk      (brk),
`endif
    .i_load     (load),
    .i_out_port (out_port),
    .i_eight    (eight),
    .i_pen      (pen),
    .i_ohel     (ohel),
    .i_btu      (btu),
    .o_doit     (doit),
    .o_tx       (tx),
    .o_txrdy    (txrdy)
  );

  typedef struct {
    logic [7:0]  data;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [10:0] frame;
    int          period;
    bit          reject;
    string       name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line bits in send order, derived from the framing rules.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic e,
                                            input logic p, input logic o);
    logic [10:0] f;
    logic        par;
    int          nd;
    f    = '1;
    f[0] = 1'b0;
    nd   = e ? 8 : 7;
    par  = o;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = d[i];
      par    = par ^ d[i];
    end
    if (p) f[1+nd] = par;
    return f;
  endfunction

  // Called just after a rising edge with the engine idle.
  task automatic run_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                           input logic [10:0] exp, input int period, input bit reject,
                           input string tag);
    out_port = d; eight = e; pen = p; ohel = o; load = 1'b1; btu = 1'b0;
    @(negedge clk);
    check({tag, " ready before load"}, txrdy, 1'b1);
    @(posedge clk); #1;
    load = 1'b0;
    out_port = 8'($urandom); eight = 1'($urandom); pen = 1'($urandom); ohel = 1'($urandom);
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < period; c++) begin
        btu  = (c == period - 1);
        load = reject && ((b == 4 && c == 0) || (b == 10 && c == period - 1));
        if (load) out_port = 8'hFF;
        @(negedge clk);
        check($sformatf("%s tx bit%0d", tag, b), tx, exp[b]);
        check($sformatf("%s doit bit%0d", tag, b), doit, 1'b1);
        check($sformatf("%s txrdy bit%0d", tag, b), txrdy, 1'b0);
        @(posedge clk); #1;
      end
    end
    load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      btu = 1'b1;
      @(negedge clk);
      check({tag, " post doit"}, doit, 1'b0);
      check({tag, " post txrdy"}, txrdy, 1'b1);
      check({tag, " post tx"}, tx, 1'b1);
      @(posedge clk); #1;
    end
    btu = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A, 4, 1'b0, "8N1_A5"};
    vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b0, 11'h406, 4, 1'b0, "8E1_03"};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 11'h606, 4, 1'b0, "8O1_03"};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 1'b0, 11'h702, 4, 1'b0, "7E1_81"};
    vecs[4] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A, 4, 1'b1, "reject_A5"};

    rst_n = 1'b0; load = 1'b0; out_port = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0; btu = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset tx", tx, 1'b1);
      check("reset doit", doit, 1'b0);
      check("reset txrdy", txrdy, 1'b1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btu = (i >= 2);
      @(negedge clk);
      check("idle tx", tx, 1'b1);
      check("idle doit", doit, 1'b0);
      check("idle txrdy", txrdy, 1'b1);
      @(posedge clk); #1;
    end
    btu = 1'b0;

    foreach (vecs[i])
      run_frame(vecs[i].data, vecs[i].eight, vecs[i].pen, vecs[i].ohel,
                vecs[i].frame, vecs[i].period, vecs[i].reject, vecs[i].name);

    out_port = 8'hA5; eight = 1'b1; pen = 1'b0; ohel = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    for (int n = 0; n < 22; n++) begin
      btu = ((n % 4) == 3);
      @(posedge clk); #1;
    end
    btu = 1'b0;
    @(negedge clk);
    check("midreset pre tx", tx, 1'b0);
    check("midreset pre doit", doit, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset async tx", tx, 1'b1);
    check("midreset async doit", doit, 1'b0);
    check("midreset async txrdy", txrdy, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 11'h74A, 4, 1'b0, "after_reset");

    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      logic       e, p, o;
      d = 8'($urandom); e = 1'($urandom); p = 1'($urandom); o = 1'($urandom);
      run_frame(d, e, p, o, ref_frame(d, e, p, o), int'($urandom_range(1, 4)),
                bit'($urandom), $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Transmit framing engine of the UART. It sits directly upstream of the bit time counter. It drives that counter's doit input and consumes its btu pulse. On each btu it shifts out one bit of an 11-bit frame: start bit, 7/8 data bits (LSB first), optional parity, then stop bits. It raises txrdy when the frame is complete.

Parameters:
FRAME_BITS, 11, bits per frame including start and trailing stop bits; the bit counter is 4 bits wide.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
load  input  1  one-cycle request to send out_port; honoured only when txrdy=1
out_port  input  8  data byte to transmit
eight  input  1  1 = 8 data bits, 0 = 7 data bits
pen  input  1  parity enable
ohel  input  1  parity sense: 0 = even, 1 = odd
btu  input  1  bit-time-up pulse from the bit time counter
doit  output  1  registered; high while a frame is in progress; drives the bit time counter
tx  output  1  serial line, idle high
txrdy  output  1  registered; high when the engine can accept load

Behaviour:
- Reset (rst_n=0, async): doit=0, txrdy=1, bit count=0, shift register all 1s, tx=1.
- IDLE state (doit=0): tx=1; btu is ignored.
- IDLE and load=1: on the next edge the engine does the following:
  - doit=1 and txrdy=0.
  - bit count=0.
  - The shift register loads sr[10:0]:
    - sr[0]=0 (start bit).
    - sr[7:1]=out_port[6:0].
    - sr[8], sr[9] set by {eight,pen}:
      - 00: 1,1
      - 01: par7,1
      - 10: out_port[7],1
      - 11: out_port[7],par8
    - sr[10]=1.
  - Parity is computed from the inputs sampled in the load cycle:
    - par7 = ^out_port[6:0] ^ ohel
    - par8 = ^out_port[7:0] ^ ohel
  - Latency: tx=0 (start bit) in the first cycle after load.
- BUSY state (doit=1): tx=sr[0].
- BUSY and btu=1, all on the same edge:
  - sr shifts right with 1 shifted into sr[10].
  - bit count increments.
- BUSY and btu=1 with count = FRAME_BITS-1: frame done.
  - doit=0, txrdy=1, count=0, sr=all 1s.
  - tx returns to idle 1.
- Frame length: exactly FRAME_BITS btu pulses, i.e. FRAME_BITS*(k+1) clocks for the counter's k.
- load while txrdy=0 (including the done cycle) is ignored. No queuing, no corruption of the current frame.
- out_port, eight, pen and ohel may change after the load cycle with no effect on the current frame.
- rst_n asserted mid-frame: immediate return to the reset values; tx goes high asynchronously.
- No combinational path from load or btu to doit or txrdy. tx is combinational from sr and doit only.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port brk (1 bit).
  - While brk=1, tx is forced to 0 and load is ignored.
  - An in-progress frame continues counting internally; its bits are masked.
  - Once brk=0, tx follows normal behaviour in the same cycle.
- Not defined: no brk port; tx behaves exactly as described above.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_n low 3 cycles, then high, no load.
   - Required: tx=1, doit=0, txrdy=1 throughout.
2. 8N1 with load out_port=8'hA5, eight=1, pen=0, btu every 4 clocks:
   - tx sequence per bit time is 0,1,0,1,0,0,1,0,1,1,1.
   - doit is high for 44 clocks.
   - txrdy rises in the cycle after the 11th btu.
3. 8E1/8O1 with out_port=8'h03, eight=1, pen=1:
   - ohel=0: bit 9 = 0.
   - ohel=1: bit 9 = 1.
   - Stop bit = 1 in both cases.
4. 7-bit parity with out_port=8'h81, eight=0, pen=1, ohel=0:
   - Bit 8 = par7 = 1.
   - Data bit 7 (1) is not transmitted.
5. Busy-load rejection:
   - Stimulus: second load with 8'hFF issued mid-frame and again in the done cycle.
   - Required: the first frame is unchanged; no second frame starts; txrdy=1 afterwards.
6. Async reset mid-frame:
   - Stimulus: rst_n low at bit 5.
   - Required: tx=1 and doit=0 immediately, before the next clock edge; a new load after release sends a clean frame.
